hamming_syndrome_gen: RTL and testbench
=======================================

// Module: hamming_syndrome_gen
// PURPOSE
//  Upstream stage of the 2-LUT data-mem address mapper. Accepts a 16-bit SEC-DED
//  Hamming codeword as two bytes (low byte first) over valid/ready, computes the
//  4-bit syndrome and overall-parity flag bit-serially, presents them as the mapper's
//  entry operand (0-15) and mux operand (0/1).
//  Codeword bit i (0..15) sits at Hamming position i; bit 0 = overall parity p0.
// PARAMETERS
//  W       8   width of Syndrome/ParityErr outputs (zero-extended), matches mapper W
// PORTS
//  Clk        in   1  single clock, rising edge
//  Reset_n    in   1  asynchronous, active-low reset
//  DataIn     in   8  codeword byte; low byte [7:0] first, then high byte [15:8]
//  InValid    in   1  DataIn valid
//  InReady    out  1  block can accept a byte this cycle
//  Syndrome   out  W  XOR of positions 1..15 whose bit is 1; value 0-15, upper bits 0
//  ParityErr  out  W  XOR of all 16 bits; 0 or 1, upper bits 0
//  OutValid   out  1  Syndrome/ParityErr valid
//  OutReady   in   1  consumer accepts result
//  ErrClass   out  2  only when HAM_ERR_CLASS_EN defined (see CONFIGURATION)
// BEHAVIOUR
//  FSM: GET_LO -> GET_HI -> CALC -> DONE -> GET_LO.
//  - GET_LO: InReady=1; on InValid, latch DataIn into cw[7:0] -> GET_HI.
//  - GET_HI: InReady=1; on InValid, latch DataIn into cw[15:8], clear accumulators,
//    idx=0 -> CALC.
//  - CALC: InReady=0; one bit per cycle, idx 0..15 (4-bit counter): if cw[idx]=1,
//    par ^= 1 and, for idx!=0, syn ^= idx. After idx=15 processed -> DONE (no wrap reuse).
//  - DONE: OutValid=1, Syndrome={0,syn}, ParityErr={0,par}; held stable until
//    OutReady=1, then -> GET_LO next cycle (InReady rises that cycle; no bypass).
//  Latency: 16 CALC cycles; OutValid asserts the cycle after the 16th CALC cycle;
//    high-byte handshake to OutValid = 17 cycles. Throughput: 1 word / >=19 cycles.
//  Output registers update only on CALC->DONE transition; outside DONE, Syndrome/
//    ParityErr hold last result, OutValid=0.
//  InValid outside GET_LO/GET_HI ignored (InReady=0, no byte consumed).
//  OutReady outside DONE ignored. OutReady high on entry to DONE: consumed that cycle.
//  Reset (async, any state, incl. mid-CALC): state=GET_LO, cw=0, syn=0, par=0, idx=0,
//    OutValid=0, Syndrome=0, ParityErr=0, ErrClass=00; InReady=1 after release.
//    Partial word discarded.
//  Interpretation (consumer-side): ParityErr=0,Syn=0 ok; ParityErr=1 single error at
//    Syn (Syn=0: p0 only); ParityErr=0,Syn!=0 double error, uncorrectable.
// CONFIGURATION
//  HAM_ERR_CLASS_EN defined: ErrClass port present, registered with Syndrome:
//    00 no error, 01 single error Syn!=0, 10 double error, 11 p0-only error.
//    Reset 00; held in DONE like other outputs.
//  HAM_ERR_CLASS_EN undefined: ErrClass port and logic absent; all else identical.
// TESTING
//  1 cw=0x0000 (lo 0x00, hi 0x00) -> Syndrome=0, ParityErr=0, ErrClass=00.
//  2 cw=0xFFFF -> Syndrome=0, ParityErr=0; OutValid exactly 17 cycles after hi accept.
//  3 cw=0x0020 (bit 5) -> Syndrome=5, ParityErr=1, ErrClass=01.
//  4 cw=0x0028 (bits 3,5) -> Syndrome=6, ParityErr=0, ErrClass=10;
//    cw=0x0001 -> Syndrome=0, ParityErr=1, ErrClass=11.
//  5 OutReady=0 for 10 cycles in DONE -> outputs stable, InReady=0, extra InValid bytes
//    not consumed; OutReady=1 -> next cycle InReady=1, state GET_LO.
//  6 Reset_n pulsed low at CALC idx=7 -> OutValid=0, Syndrome=0, InReady=1 after
//    release; next word 0x0020 -> Syndrome=5, ParityErr=1 (no stale accumulation).

Source files
------------

// File: rtl/hamming_syndrome_gen.sv
// Bit-serial SEC-DED syndrome generator: takes a 16-bit codeword as two bytes and reports
// the 4-bit syndrome and overall parity. Optional error classification under HAM_ERR_CLASS_EN.
module hamming_syndrome_gen #(
   parameter int W = 8
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic [7:0]   DataIn,
   input  logic         InValid,
   output logic         InReady,
   output logic [W-1:0] Syndrome,
   output logic [W-1:0] ParityErr,
   output logic         OutValid,
   input  logic         OutReady
`ifdef HAM_ERR_CLASS_EN
   ,
   output logic [1:0]   ErrClass
`endif
);

   localparam logic [1:0] ST_GET_LO = 2'd0;
   localparam logic [1:0] ST_GET_HI = 2'd1;
   localparam logic [1:0] ST_CALC   = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0]  state_q,   state_d;
   logic [15:0] cw_q,      cw_d;
   logic [3:0]  idx_q,     idx_d;
   logic [3:0]  syn_q,     syn_d;
   logic        par_q,     par_d;
   logic [3:0]  out_syn_q, out_syn_d;
   logic        out_par_q, out_par_d;

   logic        cur_bit;
   logic [3:0]  syn_next;
   logic        par_next;

   // Position 0 is the overall parity bit: it feeds the parity but never the syndrome.
   always_comb begin
      cur_bit  = cw_q[idx_q];
      syn_next = (cur_bit && (idx_q != 4'd0)) ? (syn_q ^ idx_q) : syn_q;
      par_next = par_q ^ cur_bit;
   end

   always_comb begin
      // NOTE: every next-state variable defaults to its current value first, so no
      // path through the case leaves it unassigned and no latch is inferred.
      state_d   = state_q;
      cw_d      = cw_q;
      idx_d     = idx_q;
      syn_d     = syn_q;
      par_d     = par_q;
      out_syn_d = out_syn_q;
      out_par_d = out_par_q;
      case (state_q)
         ST_GET_LO: begin
            if (InValid) begin
               cw_d[7:0] = DataIn;
               state_d   = ST_GET_HI;
            end
         end
         ST_GET_HI: begin
            if (InValid) begin
               cw_d[15:8] = DataIn;
               syn_d      = 4'd0;
               par_d      = 1'b0;
               idx_d      = 4'd0;
               state_d    = ST_CALC;
            end
         end
         ST_CALC: begin
            syn_d = syn_next;
            par_d = par_next;
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
               out_syn_d = syn_next;
               out_par_d = par_next;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (OutReady) begin
               state_d = ST_GET_LO;
            end
         end
         default: state_d = ST_GET_LO;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= ST_GET_LO;
         cw_q      <= '0;
         idx_q     <= '0;
         syn_q     <= '0;
         par_q     <= 1'b0;
         out_syn_q <= '0;
         out_par_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cw_q      <= cw_d;
         idx_q     <= idx_d;
         syn_q     <= syn_d;
         par_q     <= par_d;
         out_syn_q <= out_syn_d;
         out_par_q <= out_par_d;
      end
   end

   assign InReady   = (state_q == ST_GET_LO) || (state_q == ST_GET_HI);
   assign OutValid  = (state_q == ST_DONE);
   assign Syndrome  = W'(out_syn_q);
   assign ParityErr = W'(out_par_q);

`ifdef HAM_ERR_CLASS_EN
   logic [1:0] err_class_q, err_class_d;

   // 00 clean, 01 correctable at syndrome, 10 double error, 11 only p0 flipped.
   always_comb begin
      err_class_d = err_class_q;
      if ((state_q == ST_CALC) && (idx_q == 4'd15)) begin
         if (par_next) begin
            err_class_d = (syn_next == 4'd0) ? 2'b11 : 2'b01;
         end else begin
            err_class_d = (syn_next == 4'd0) ? 2'b00 : 2'b10;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         err_class_q <= 2'b00;
      end else begin
         err_class_q <= err_class_d;
      end
   end

   assign ErrClass = err_class_q;
`endif

endmodule

// File: tb/tb_hamming_syndrome_gen.sv
// Directed and random stimulus for hamming_syndrome_gen, checked against a parity-mask
// reference model; ErrClass is checked when HAM_ERR_CLASS_EN is defined.
module tb_hamming_syndrome_gen;

   localparam int W = 8;

   logic         Clk     = 1'b0;
   logic         Reset_n = 1'b0;
   logic [7:0]   DataIn  = '0;
   logic         InValid = 1'b0;
   logic         OutReady = 1'b0;
   logic         InReady;
   logic [W-1:0] Syndrome;
   logic [W-1:0] ParityErr;
   logic         OutValid;
`ifdef HAM_ERR_CLASS_EN
   logic [1:0]   ErrClass;
`endif

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   hamming_syndrome_gen #(.W(W)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .DataIn    (DataIn),
      .InValid   (InValid),
      .InReady   (InReady),
      .Syndrome  (Syndrome),
      .ParityErr (ParityErr),
      .OutValid  (OutValid),
      .OutReady  (OutReady)
`ifdef HAM_ERR_CLASS_EN
      ,
      .ErrClass  (ErrClass)
`endif
   );

   // Each syndrome bit k is the parity of the codeword positions whose index has bit k set.
   function automatic logic [3:0] model_syn(input logic [15:0] cw);
      return {^(cw & 16'hFF00), ^(cw & 16'hF0F0), ^(cw & 16'hCCCC), ^(cw & 16'hAAAA)};
   endfunction

   function automatic logic [1:0] model_class(input logic [15:0] cw);
      logic [3:0] s;
      s = model_syn(cw);
      if (^cw) return (s == 4'd0) ? 2'b11 : 2'b01;
      return (s == 4'd0) ? 2'b00 : 2'b10;
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_in_ready(input string tag);
      int n = 0;
      while (!InReady && n < 50) begin
         cycle();
         n++;
      end
      if (!InReady) check(tag, 32'(InReady), 32'd1);
   endtask

   task automatic apply_reset();
      Reset_n = 1'b0;
      cycle();
      @(negedge Clk);
      Reset_n = 1'b1;
      cycle();
   endtask

   // Sends one word, checks latency and result, optionally stalls the consumer.
   task automatic run_word(input logic [15:0] cw, input int stall);
      logic [3:0] es;
      logic       ep;
      int         n;
      es = model_syn(cw);
      ep = ^cw;
      OutReady = (stall == 0);
      DataIn   = cw[7:0];
      InValid  = 1'b1;
      wait_in_ready("lo_ready_timeout");
      cycle();
      DataIn = cw[15:8];
      wait_in_ready("hi_ready_timeout");
      n = 0;
      do begin
         cycle();
         n++;
         InValid = 1'(($urandom % 2));
         DataIn  = 8'($urandom);
      end while (!OutValid && n < 40);
      InValid = 1'b0;
      check("latency_hi_to_outvalid", 32'(n), 32'd17);
      check("syndrome", 32'(Syndrome), 32'(es));
      check("parity_err", 32'(ParityErr), 32'(ep));
      check("in_ready_in_done", 32'(InReady), 32'd0);
`ifdef HAM_ERR_CLASS_EN
      check("err_class", 32'(ErrClass), 32'(model_class(cw)));
`endif
      for (int i = 0; i < stall; i++) begin
         InValid = 1'b1;
         DataIn  = 8'($urandom);
         cycle();
         check("stall_out_valid", 32'(OutValid), 32'd1);
         check("stall_in_ready", 32'(InReady), 32'd0);
         check("stall_syndrome", 32'(Syndrome), 32'(es));
         check("stall_parity_err", 32'(ParityErr), 32'(ep));
      end
      InValid  = 1'b0;
      OutReady = 1'b1;
      cycle();
      OutReady = 1'b0;
      check("post_done_in_ready", 32'(InReady), 32'd1);
      check("post_done_out_valid", 32'(OutValid), 32'd0);
      check("post_done_syndrome_held", 32'(Syndrome), 32'(es));
   endtask

   initial begin
      logic [15:0] cw;

      // Reset state
      Reset_n = 1'b0;
      InValid = 1'b1;
      DataIn  = 8'hA5;
      cycle();
      check("reset_out_valid", 32'(OutValid), 32'd0);
      check("reset_syndrome", 32'(Syndrome), 32'd0);
      check("reset_parity_err", 32'(ParityErr), 32'd0);
`ifdef HAM_ERR_CLASS_EN
      check("reset_err_class", 32'(ErrClass), 32'd0);
`endif
      InValid = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      cycle();
      check("post_reset_in_ready", 32'(InReady), 32'd1);

      // Directed words
      run_word(16'h0000, 0);
      run_word(16'hFFFF, 0);
      run_word(16'h0020, 1);
      run_word(16'h0028, 0);
      run_word(16'h0001, 2);
      run_word(16'h8421, 10);

      // Reset mid-CALC with idx at 7, after a result of 5/1 is on the outputs
      run_word(16'h0020, 0);
      cw = 16'h7EF0;
      DataIn  = cw[7:0];
      InValid = 1'b1;
      wait_in_ready("rst_lo_ready_timeout");
      cycle();
      DataIn = cw[15:8];
      wait_in_ready("rst_hi_ready_timeout");
      cycle();
      InValid = 1'b0;
      repeat (7) cycle();
      Reset_n = 1'b0;
      #1;
      check("midcalc_reset_out_valid", 32'(OutValid), 32'd0);
      check("midcalc_reset_syndrome", 32'(Syndrome), 32'd0);
      check("midcalc_reset_parity_err", 32'(ParityErr), 32'd0);
      check("midcalc_reset_in_ready", 32'(InReady), 32'd1);
      @(negedge Clk);
      Reset_n = 1'b1;
      cycle();
      check("midcalc_release_in_ready", 32'(InReady), 32'd1);
      run_word(16'h0020, 0);

      // Partial word (low byte only) discarded by reset
      DataIn  = 8'hFF;
      InValid = 1'b1;
      cycle();
      InValid = 1'b0;
      apply_reset();
      run_word(16'h0028, 0);

      // Randomized words with random consumer back-pressure
      for (int k = 0; k < 24; k++) begin
         cw = 16'($urandom);
         if (k % 3 == 0) cw = 16'(1) << $urandom_range(0, 15);
         run_word(cw, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
